// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store sub-word alignment unit:
//   - RISC-V funct3 width/sign codes used by loads and stores
//   - lsu_state_t : IDLE (accepting requests) / WRITE (second half of a
//                   sub-word read-modify-write)
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the sub-word load/store unit.
//
// Ports:
//   dmRdata_i    in  32 : word read from data memory (word-aligned address)
//   wdata_i      in  32 : store data; low byte / halfword used for SB / SH
//   addrLo_i     in   2 : byte offset within the word (addr[1:0])
//   funct3_i     in   3 : RISC-V width/sign code
//   loadData_o   out 32 : extracted and sign/zero-extended load result
//   mergedWord_o out 32 : dmRdata_i with the addressed lane replaced by the
//                         store data (unchanged for any non-B/H code)
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] dmRdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addrLo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] loadData_o,
  output logic [31:0] mergedWord_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  // Select the addressed byte and halfword lanes out of the memory word.
  always_comb begin
    byteLane = dmRdata_i[7:0];
    case (addrLo_i)
      2'd0:    byteLane = dmRdata_i[7:0];
      2'd1:    byteLane = dmRdata_i[15:8];
      2'd2:    byteLane = dmRdata_i[23:16];
      default: byteLane = dmRdata_i[31:24];
    endcase
    halfLane = addrLo_i[1] ? dmRdata_i[31:16] : dmRdata_i[15:0];
  end

  // Extend the selected lane to 32 bits; undefined codes produce zero so a
  // faulting request never shows stale data.
  always_comb begin
    loadData_o = 32'h0;
    case (funct3_i)
      F3_B:    loadData_o = {{24{byteLane[7]}}, byteLane};
      F3_H:    loadData_o = {{16{halfLane[15]}}, halfLane};
      F3_W:    loadData_o = dmRdata_i;
      F3_BU:   loadData_o = {24'h0, byteLane};
      F3_HU:   loadData_o = {16'h0, halfLane};
      default: loadData_o = 32'h0;
    endcase
  end

  // Build the full word for a sub-word store: start from the current memory
  // contents and overwrite only the addressed lane.
  always_comb begin
    mergedWord_o = dmRdata_i;
    case (funct3_i)
      F3_B: begin
        case (addrLo_i)
          2'd0:    mergedWord_o[7:0]   = wdata_i[7:0];
          2'd1:    mergedWord_o[15:8]  = wdata_i[7:0];
          2'd2:    mergedWord_o[23:16] = wdata_i[7:0];
          default: mergedWord_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (addrLo_i[1]) begin
          mergedWord_o[31:16] = wdata_i[15:0];
        end else begin
          mergedWord_o[15:0] = wdata_i[15:0];
        end
      end
      default: mergedWord_o = dmRdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// ---------------------------------------------------------------------------
// lsu_subword
// Load/store alignment unit between the MEM stage and a word-write-only,
// byte-addressed data memory. Loads and SW finish in the request cycle;
// SB/SH run as a two-cycle read-modify-write that stalls the pipeline for
// one cycle. Misaligned and illegal requests are flagged and never reach
// memory.
//
// Ports:
//   clk        in  1  : clock, rising edge
//   reset      in  1  : synchronous, active-high
//   req_valid  in  1  : MEM-stage request this cycle
//   req_store  in  1  : 1 = store, 0 = load
//   funct3     in  3  : RISC-V width/sign code
//   addr       in  32 : byte address
//   wdata      in  32 : store data
//   rdata      out 32 : extended load result (valid with done on a load)
//   done       out 1  : access completes this cycle
//   stall      out 1  : pipeline must hold the MEM request
//   misaligned out 1  : alignment fault on the current request
//   illegal    out 1  : undefined funct3 on the current request
//   dm_addr    out 32 : word-aligned memory address
//   dm_wdata   out 32 : full word to write
//   dm_rw      out 1  : memory write strobe
//   dm_rdata   in  32 : combinational memory read word at dm_addr
// ---------------------------------------------------------------------------
module lsu_subword
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_rw,
  input  logic [31:0] dm_rdata
);

  lsu_state_t  state_q, state_d;
  logic [31:0] heldAddr_q, heldAddr_d;
  logic [31:0] merged_q, merged_d;

  logic        isIllegal;
  logic        isMisaligned;
  logic        isFault;
  logic        isSubwordStore;
  logic        startRmw;
  logic [31:0] alignedAddr;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign alignedAddr = {addr[31:2], 2'b00};

  lsu_align u_align (
    .dmRdata_i    (dm_rdata),
    .wdata_i      (wdata),
    .addrLo_i     (addr[1:0]),
    .funct3_i     (funct3),
    .loadData_o   (loadData),
    .mergedWord_o (mergedWord)
  );

  // Fault decode. BU/HU only exist as loads, so a store with those codes is
  // illegal. Misalignment is suppressed when the code is already illegal.
  always_comb begin
    isIllegal = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: isIllegal = 1'b0;
      F3_BU, F3_HU:     isIllegal = req_store;
      default:          isIllegal = 1'b1;
    endcase

    isMisaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: isMisaligned = addr[0];
      F3_W:        isMisaligned = (addr[1:0] != 2'b00);
      default:     isMisaligned = 1'b0;
    endcase
    if (isIllegal) begin
      isMisaligned = 1'b0;
    end
  end

  assign isFault        = isIllegal | isMisaligned;
  // After fault screening, any store that is not a word store is SB or SH.
  assign isSubwordStore = req_store & (funct3 != F3_W);
  assign startRmw       = (state_q == IDLE) & req_valid & ~isFault & isSubwordStore;

  // State and hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      heldAddr_q <= 32'h0;
      merged_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      heldAddr_q <= heldAddr_d;
      merged_q   <= merged_d;
    end
  end

  // Next-state logic. The address and merged word are captured on the read
  // half of a sub-word store, because the request may change once the
  // pipeline advances after WRITE.
  always_comb begin
    state_d    = state_q;
    heldAddr_d = heldAddr_q;
    merged_d   = merged_q;
    case (state_q)
      IDLE: begin
        if (startRmw) begin
          state_d    = WRITE;
          heldAddr_d = alignedAddr;
          merged_d   = mergedWord;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. In WRITE the request inputs are ignored entirely; a reset
  // arriving in that cycle cancels the write.
  always_comb begin
    rdata      = 32'h0;
    done       = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    dm_addr    = alignedAddr;
    dm_wdata   = wdata;
    dm_rw      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          illegal    = isIllegal;
          misaligned = isMisaligned;
          if (!isFault) begin
            if (!req_store) begin
              done  = 1'b1;
              rdata = loadData;
            end else if (!isSubwordStore) begin
              done  = 1'b1;
              dm_rw = 1'b1;
            end else begin
              stall = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        dm_addr  = heldAddr_q;
        dm_wdata = merged_q;
        dm_rw    = ~reset;
        done     = ~reset;
      end
      default: begin
        dm_rw = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_subword.sv
// ---------------------------------------------------------------------------
// tb_lsu_subword
// Scoreboard bench for lsu_subword. The driver pushes the expected outcome
// of each request (computed from a byte-array memory model) into a queue;
// a monitor on the falling edge pops and compares whenever the DUT
// completes or faults a request. A word-array memory attached to the DUT
// ports plays the role of the real data memory.
// ---------------------------------------------------------------------------
module tb_lsu_subword;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misaligned;
  logic        illegal;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic        dmRw;
  logic [31:0] dmRdata;

  always #5 clk = ~clk;

  lsu_subword dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_store  (reqStore),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .stall      (stall),
    .misaligned (misaligned),
    .illegal    (illegal),
    .dm_addr    (dmAddr),
    .dm_wdata   (dmWdata),
    .dm_rw      (dmRw),
    .dm_rdata   (dmRdata)
  );

  // Environment memory: 4 KiB of words, written only by this process.
  logic [31:0] dutMem [0:1023];
  logic        memClear;
  logic        preloadEn;
  logic [31:0] preloadAddr;
  logic [31:0] preloadData;

  assign dmRdata = dutMem[dmAddr[11:2]];

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 1024; i++) dutMem[i] <= 32'h0;
    end else if (preloadEn) begin
      dutMem[preloadAddr[11:2]] <= preloadData;
    end else if (dmRw) begin
      dutMem[dmAddr[11:2]] <= dmWdata;
    end
  end

  // Reference model memory, one entry per byte.
  logic [7:0] refMem [0:4095];

  typedef struct {
    bit          fault;
    bit          expMis;
    bit          expIll;
    bit          isLoad;
    logic [31:0] expRdata;
    logic [31:0] expAddr;
    logic [31:0] expWord;
    int          expStalls;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  bit   prevStall = 1'b0;
  int   stallCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit refIllegal(input bit store, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] a);
    int base;
    base = int'({a[11:2], 2'b00});
    return {refMem[base + 3], refMem[base + 2], refMem[base + 1], refMem[base]};
  endfunction

  // Monitor: pops one expectation per completed or faulted request.
  always @(negedge clk) begin
    exp_t e;
    if (reset || memClear) begin
      prevStall  = 1'b0;
      stallCount = 0;
    end else begin
      if (stall) begin
        checkOutput("stall_not_consecutive", 32'(prevStall), 32'h0);
        checkOutput("stall_cycle_no_write", 32'(dmRw), 32'h0);
        stallCount++;
      end
      if (done || misaligned || illegal) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_completion: got done=%0b mis=%0b ill=%0b expected none",
                   done, misaligned, illegal);
        end else begin
          e = expQ.pop_front();
          checkOutput("misaligned_flag", 32'(misaligned), 32'(e.expMis));
          checkOutput("illegal_flag", 32'(illegal), 32'(e.expIll));
          if (e.fault) begin
            checkOutput("fault_done", 32'(done), 32'h0);
            checkOutput("fault_no_write", 32'(dmRw), 32'h0);
            checkOutput("fault_rdata", rdata, 32'h0);
            checkOutput("fault_stall", 32'(stall), 32'h0);
          end else if (e.isLoad) begin
            checkOutput("load_rdata", rdata, e.expRdata);
            checkOutput("load_addr", dmAddr, e.expAddr);
            checkOutput("load_no_write", 32'(dmRw), 32'h0);
          end else begin
            checkOutput("store_write", 32'(dmRw), 32'h1);
            checkOutput("store_addr", dmAddr, e.expAddr);
            checkOutput("store_word", dmWdata, e.expWord);
            checkOutput("store_stall_cycles", 32'(stallCount), 32'(e.expStalls));
          end
        end
        stallCount = 0;
      end else if (!stall) begin
        checkOutput("idle_no_write", 32'(dmRw), 32'h0);
      end
      prevStall = stall;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    int base;
    base = int'({a[11:2], 2'b00});
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = w;
    for (int i = 0; i < 4; i++) refMem[base + i] = w[8*i +: 8];
    @(posedge clk);
    #1;
    preloadEn = 1'b0;
  endtask

  // Drives one request (entered and left at posedge+1), holding it while
  // the DUT stalls, and pushes the model's expected outcome.
  task automatic applyStimulus(input bit store, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          sz;
    int          base;
    bit          ill;
    bit          mis;
    bit          finished;
    logic [31:0] v;

    reqValid = 1'b1;
    reqStore = store;
    funct3   = f3;
    addr     = a;
    wdata    = wd;

    ill = refIllegal(store, f3);
    sz  = accessSize(f3);
    mis = 1'b0;
    if (!ill) mis = (int'(a[11:0]) % sz) != 0;
    base = int'(a[11:0]);

    e.fault     = ill || mis;
    e.expMis    = mis;
    e.expIll    = ill;
    e.isLoad    = !store;
    e.expRdata  = 32'h0;
    e.expAddr   = {a[31:2], 2'b00};
    e.expWord   = 32'h0;
    e.expStalls = (store && sz < 4) ? 1 : 0;

    if (!e.fault) begin
      if (!store) begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(refMem[base + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        e.expRdata = v;
      end else begin
        for (int i = 0; i < sz; i++) refMem[base + i] = wd[8*i +: 8];
        e.expWord = refWord(a);
      end
    end
    expQ.push_back(e);

    finished = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || misaligned || illegal) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL request_timeout: got no completion expected one within 4 cycles (addr 0x%08h)", a);
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // SB whose WRITE cycle is hit by reset: the write must be cancelled.
  task automatic resetDuringWrite(input logic [31:0] a, input logic [31:0] wd);
    reqValid = 1'b1;
    reqStore = 1'b1;
    funct3   = F3_B;
    addr     = a;
    wdata    = wd;
    @(negedge clk);
    checkOutput("rst_rmw_stall", 32'(stall), 32'h1);
    checkOutput("rst_rmw_read_no_write", 32'(dmRw), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_write_cancelled", 32'(dmRw), 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_after_stall", 32'(stall), 32'h0);
    checkOutput("rst_after_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sz;

    reset       = 1'b1;
    memClear    = 1'b1;
    preloadEn   = 1'b0;
    preloadAddr = 32'h0;
    preloadData = 32'h0;
    reqValid    = 1'b0;
    reqStore    = 1'b0;
    funct3      = 3'b000;
    addr        = 32'h0;
    wdata       = 32'h0;
    for (int i = 0; i < 4096; i++) refMem[i] = 8'h0;

    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    memClear = 1'b0;

    @(negedge clk);
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_dm_rw", 32'(dmRw), 32'h0);
    checkOutput("reset_misaligned", 32'(misaligned), 32'h0);
    checkOutput("reset_illegal", 32'(illegal), 32'h0);
    @(posedge clk);
    #1;

    preload(32'h100, 32'h8899AABB);
    preload(32'h300, 32'hAABBCCDD);

    applyStimulus(1'b0, F3_B,  32'h101, 32'h0);
    applyStimulus(1'b0, F3_BU, 32'h101, 32'h0);
    applyStimulus(1'b0, F3_H,  32'h102, 32'h0);
    applyStimulus(1'b0, F3_HU, 32'h102, 32'h0);

    applyStimulus(1'b1, F3_W, 32'h200, 32'h12345678);
    applyStimulus(1'b0, F3_W, 32'h200, 32'h0);

    applyStimulus(1'b1, F3_B, 32'h302, 32'hCAFE0055);
    applyStimulus(1'b1, F3_H, 32'h300, 32'h99991234);
    applyStimulus(1'b0, F3_W, 32'h300, 32'h0);

    applyStimulus(1'b0, F3_W,   32'h201, 32'h0);
    applyStimulus(1'b1, F3_H,   32'h303, 32'hFFFF);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0);
    applyStimulus(1'b1, F3_BU,  32'h104, 32'h77);
    applyStimulus(1'b1, 3'b111, 32'h302, 32'h77);
    applyStimulus(1'b0, F3_W,   32'h200, 32'h0);

    resetDuringWrite(32'h300, 32'h66);
    applyStimulus(1'b0, F3_W, 32'h300, 32'h0);

    applyStimulus(1'b1, F3_B, 32'h400, 32'h11);
    applyStimulus(1'b1, F3_B, 32'h403, 32'h22);
    applyStimulus(1'b0, F3_W, 32'h400, 32'h0);

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255)) + 32'h100;
      sz = accessSize(f3);
      if (sz > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      applyStimulus(st, f3, a, $urandom);
      if ($urandom_range(0, 4) == 0) idleCycles(1);
    end

    idleCycles(2);
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
